// File: rtl/midi_controller.sv
// MIDI byte-stream parser: tracks running status and emits one-cycle event strobes
// with registered note/velocity/channel/addr fields for channel-voice messages.
module midi_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_byte,
  input  logic [7:0] data,
  output logic       note_pressed,
  output logic       note_release,
  output logic       note_keypress,
  output logic       pitch_wheel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic       rst_cmd,
  output logic [7:0] addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_D1 = 2'd1, WAIT_D2 = 2'd2} state_t;

  state_t     state;
  logic [3:0] rs_type;
  logic [3:0] rs_chan;
  logic [6:0] d1;

  // Parser state, running status and registered outputs; strobes self-clear every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rs_type       <= 4'h0;
      rs_chan       <= 4'h0;
      d1            <= 7'h00;
      note_pressed  <= 1'b0;
      note_release  <= 1'b0;
      note_keypress <= 1'b0;
      pitch_wheel   <= 1'b0;
      rst_cmd       <= 1'b0;
      note          <= 7'h00;
      velocity      <= 7'h00;
      channel       <= 4'h0;
      addr          <= 8'h00;
    end else begin
      note_pressed  <= 1'b0;
      note_release  <= 1'b0;
      note_keypress <= 1'b0;
      pitch_wheel   <= 1'b0;
      rst_cmd       <= 1'b0;
      if (valid_byte) begin
        if (data[7]) begin
          if (data[7:4] != 4'hF) begin
            rs_type <= data[7:4];
            rs_chan <= data[3:0];
            state   <= WAIT_D1;
          end else if (data == 8'hFF) begin
            rst_cmd <= 1'b1;
            rs_type <= 4'h0;
            rs_chan <= 4'h0;
            state   <= IDLE;
          end else if (!data[3]) begin
            // System common / SysEx: cancels running status
            rs_type <= 4'h0;
            rs_chan <= 4'h0;
            state   <= IDLE;
          end else begin
            state <= state;
          end
        end else begin
          case (state)
            IDLE: begin
              state <= IDLE;
            end
            WAIT_D1: begin
              if ((rs_type == 4'hC) || (rs_type == 4'hD)) begin
                state <= WAIT_D1;
              end else begin
                d1    <= data[6:0];
                state <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              state <= WAIT_D1;
              case (rs_type)
                4'h9: begin
                  note    <= d1;
                  channel <= rs_chan;
                  if (data[6:0] != 7'h00) begin
                    velocity     <= data[6:0];
                    note_pressed <= 1'b1;
                  end else begin
                    velocity     <= 7'h00;
                    note_release <= 1'b1;
                  end
                end
                4'h8: begin
                  note         <= d1;
                  velocity     <= data[6:0];
                  channel      <= rs_chan;
                  note_release <= 1'b1;
                end
                4'hA: begin
                  note          <= d1;
                  velocity      <= data[6:0];
                  channel       <= rs_chan;
                  note_keypress <= 1'b1;
                end
                4'hE: begin
                  velocity    <= d1;
                  note        <= data[6:0];
                  channel     <= rs_chan;
                  pitch_wheel <= 1'b1;
                end
                4'hB: begin
                  addr     <= {1'b0, d1};
                  velocity <= data[6:0];
                  channel  <= rs_chan;
                end
                default: begin
                  state <= WAIT_D1;
                end
              endcase
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_controller.sv
// Self-checking bench for midi_controller: directed scenarios plus a random byte stream
// compared against a message-level reference model (status byte + collected data list).
module tb_midi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_byte = 1'b0;
  logic [7:0] data = 8'h00;
  logic       note_pressed, note_release, note_keypress, pitch_wheel, rst_cmd;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic [7:0] addr;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int   m_status = -1;
  int   m_args[$];
  logic m_press, m_rel, m_key, m_pitch, m_rcmd;
  logic [6:0] m_note, m_vel;
  logic [3:0] m_chan;
  logic [7:0] m_addr;

  midi_controller dut (
    .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
    .note_pressed(note_pressed), .note_release(note_release),
    .note_keypress(note_keypress), .pitch_wheel(pitch_wheel),
    .note(note), .velocity(velocity), .channel(channel),
    .rst_cmd(rst_cmd), .addr(addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_status = -1;
    m_args.delete();
    {m_press, m_rel, m_key, m_pitch, m_rcmd} = 5'b0;
    m_note = 7'h00; m_vel = 7'h00; m_chan = 4'h0; m_addr = 8'h00;
  endtask

  task automatic model_byte(input logic v, input logic [7:0] b);
    int t, ch, a, c;
    {m_press, m_rel, m_key, m_pitch, m_rcmd} = 5'b0;
    if (!v) return;
    if (b == 8'hFF) begin
      m_rcmd = 1'b1; m_status = -1; m_args.delete();
    end else if (b >= 8'hF8) begin
      // real-time: invisible
    end else if (b >= 8'hF0) begin
      m_status = -1; m_args.delete();
    end else if (b >= 8'h80) begin
      m_status = b; m_args.delete();
    end else if (m_status >= 0) begin
      m_args.push_back(int'(b));
      t  = m_status / 16;
      ch = m_status % 16;
      if (m_args.size() == ((t == 12 || t == 13) ? 1 : 2)) begin
        a = m_args[0];
        c = (m_args.size() > 1) ? m_args[1] : 0;
        m_args.delete();
        if (t == 9 && c != 0) begin m_note = a[6:0]; m_vel = c[6:0]; m_chan = ch[3:0]; m_press = 1'b1; end
        else if (t == 9)      begin m_note = a[6:0]; m_vel = 7'h00; m_chan = ch[3:0]; m_rel = 1'b1; end
        else if (t == 8)      begin m_note = a[6:0]; m_vel = c[6:0]; m_chan = ch[3:0]; m_rel = 1'b1; end
        else if (t == 10)     begin m_note = a[6:0]; m_vel = c[6:0]; m_chan = ch[3:0]; m_key = 1'b1; end
        else if (t == 14)     begin m_vel = a[6:0]; m_note = c[6:0]; m_chan = ch[3:0]; m_pitch = 1'b1; end
        else if (t == 11)     begin m_addr = {1'b0, a[6:0]}; m_vel = c[6:0]; m_chan = ch[3:0]; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".note_pressed"},  {7'h00, note_pressed},  {7'h00, m_press});
    chk({tag, ".note_release"},  {7'h00, note_release},  {7'h00, m_rel});
    chk({tag, ".note_keypress"}, {7'h00, note_keypress}, {7'h00, m_key});
    chk({tag, ".pitch_wheel"},   {7'h00, pitch_wheel},   {7'h00, m_pitch});
    chk({tag, ".rst_cmd"},       {7'h00, rst_cmd},       {7'h00, m_rcmd});
    chk({tag, ".note"},          {1'b0, note},           {1'b0, m_note});
    chk({tag, ".velocity"},      {1'b0, velocity},       {1'b0, m_vel});
    chk({tag, ".channel"},       {4'h0, channel},        {4'h0, m_chan});
    chk({tag, ".addr"},          addr,                   m_addr);
    chk({tag, ".onehot"},        8'($countones({note_pressed, note_release, note_keypress, pitch_wheel}) <= 1), 8'h01);
  endtask

  // drive one cycle (called just after a rising edge), then check just after the next edge
  task automatic step(input logic v, input logic [7:0] b, input string tag);
    valid_byte = v;
    data = b;
    model_byte(v, b);
    @(posedge clk);
    #1;
    valid_byte = 1'b0;
    check_all(tag);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    step(1'b1, b, tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all({tag, ".async"});
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state");
    rst = 1'b0;
    step(1'b0, 8'h00, "idle");

    // note-on channel 3
    send(8'h93, "r38a"); send(8'h3C, "r38b"); send(8'h64, "r38c");
    chk("r38.pressed", {7'h00, note_pressed}, 8'h01);
    chk("r38.note", {1'b0, note}, 8'h3C);
    chk("r38.chan", {4'h0, channel}, 8'h03);
    step(1'b0, 8'h00, "r38.drop");
    chk("r38.pulse_len", {7'h00, note_pressed}, 8'h00);

    // running status: note-on then velocity-0 note-off
    send(8'h90, "r39a"); send(8'h40, "r39b"); send(8'h7F, "r39c");
    send(8'h40, "r39d"); send(8'h00, "r39e");
    chk("r39.release", {7'h00, note_release}, 8'h01);
    chk("r39.vel0", {1'b0, velocity}, 8'h00);

    // pitch bend
    send(8'hE1, "r40a"); send(8'h05, "r40b"); send(8'h40, "r40c");
    chk("r40.pitch", {7'h00, pitch_wheel}, 8'h01);
    chk("r40.msb", {1'b0, note}, 8'h40);
    chk("r40.lsb", {1'b0, velocity}, 8'h05);

    // real-time byte mid-message
    send(8'h90, "r41a"); send(8'h3C, "r41b"); send(8'hF8, "r41c"); send(8'h50, "r41d");
    chk("r41.pressed", {7'h00, note_pressed}, 8'h01);
    chk("r41.vel", {1'b0, velocity}, 8'h50);

    // control change, system reset, orphan data
    send(8'hB2, "r42a"); send(8'h07, "r42b"); send(8'h55, "r42c");
    chk("r42.addr", addr, 8'h07);
    send(8'hFF, "r42d");
    chk("r42.rst_cmd", {7'h00, rst_cmd}, 8'h01);
    send(8'h3C, "r42e"); send(8'h10, "r42f");

    // one-byte type and key pressure, abort by new status
    send(8'hC4, "pc_a"); send(8'h11, "pc_b");
    send(8'hA5, "kp_a"); send(8'h22, "kp_b"); send(8'h33, "kp_c");
    send(8'h86, "ab_a"); send(8'h10, "ab_b"); send(8'h87, "ab_c"); send(8'h11, "ab_d"); send(8'h12, "ab_e");
    send(8'h92, "sx_a"); send(8'hF0, "sx_b"); send(8'h12, "sx_c"); send(8'h13, "sx_d");

    // reset mid-message
    send(8'h90, "r43a");
    pulse_reset("r43");
    send(8'h3C, "r43b"); send(8'h10, "r43c");
    chk("r43.nostrobe", {7'h00, note_pressed}, 8'h00);

    // random stream
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 52) b = 8'h00;
      else if (r < 82) b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFE));
      else if (r < 94) b = 8'hFF;
      else             b = 8'($urandom_range(8'hF0, 8'hF7));
      if ($urandom_range(0, 299) == 0) pulse_reset("rnd_rst");
      step($urandom_range(0, 3) != 0, b, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
